// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between the two requesters / consumer and the mux select arbiter.
// The master side drives the requests and consumer ready; the slave (arbiter) side drives select and grants.
interface mux_sel_arbiter_if;
  logic       req_0;
  logic       req_1;
  logic       out_ready;
  logic       sel;
  logic       gnt_0;
  logic       gnt_1;
  logic       out_valid;
  logic [7:0] burst_cnt;

  modport master (
    output req_0, req_1, out_ready,
    input  sel, gnt_0, gnt_1, out_valid, burst_cnt
  );

  modport slave (
    input  req_0, req_1, out_ready,
    output sel, gnt_0, gnt_1, out_valid, burst_cnt
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select line of a 2:1 data mux, with a bounded burst
// length per owner and a valid/ready handshake toward the consumer.
module mux_sel_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux_sel_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t     state_q;
  logic       sel_q;
  logic       last_q;
  logic [7:0] cnt_q;

  logic own, req_own, req_oth, valid, xfer, wrap, pick;

  assign own     = (state_q == OWN1);
  assign req_own = own ? bus.req_1 : bus.req_0;
  assign req_oth = own ? bus.req_0 : bus.req_1;
  assign valid   = (state_q == OWN0 || state_q == OWN1) && req_own;
  assign xfer    = valid && bus.out_ready;
  assign wrap    = ({1'b0, cnt_q} + 9'd1) == 9'(BURST_MAX);
  // Contended pick from IDLE goes to whoever did not own last.
  assign pick    = (bus.req_0 && bus.req_1) ? ~last_q : bus.req_1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_0 || bus.req_1) begin
            state_q <= pick ? OWN1 : OWN0;
            sel_q   <= pick;
            last_q  <= pick;
            cnt_q   <= 8'd0;
          end
        end
        OWN0, OWN1: begin
          if (!req_own) begin
            cnt_q <= 8'd0;
            if (req_oth) begin
              state_q <= own ? OWN0 : OWN1;
              sel_q   <= ~own;
              last_q  <= ~own;
            end else begin
              state_q <= IDLE;
            end
          end else if (xfer) begin
            if (wrap) begin
              // Burst limit reached: hand over only if the other side is waiting.
              cnt_q <= 8'd0;
              if (req_oth) begin
                state_q <= own ? OWN0 : OWN1;
                sel_q   <= ~own;
                last_q  <= ~own;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt_0     = (state_q == OWN0);
  assign bus.gnt_1     = (state_q == OWN1);
  assign bus.out_valid = valid;
  assign bus.burst_cnt = cnt_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: directed scenarios with literal expectations plus a randomized
// run, all checked every cycle against an ownership/burst model of the arbitration rules.
module tb_mux_sel_arbiter;

  localparam int BM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mux_sel_arbiter_if bus();

  mux_sel_arbiter #(.BURST_MAX(BM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner is -1 when nobody holds the mux.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_last  = 1;
  int m_sel   = 0;

  function automatic int rq(input int s);
    return (s == 0) ? int'(bus.req_0) : int'(bus.req_1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = 1; m_sel = 0;
    end else if (m_owner < 0) begin
      int w;
      w = -1;
      if (bus.req_0 && bus.req_1) w = 1 - m_last;
      else if (bus.req_0)         w = 0;
      else if (bus.req_1)         w = 1;
      if (w >= 0) begin m_owner = w; m_sel = w; m_last = w; m_cnt = 0; end
    end else begin
      int x;
      x = m_owner;
      if (rq(x) == 0) begin
        m_cnt = 0;
        if (rq(1 - x) != 0) begin m_owner = 1 - x; m_sel = 1 - x; m_last = 1 - x; end
        else m_owner = -1;
      end else if (bus.out_ready) begin
        if (m_cnt + 1 == BM) begin
          m_cnt = 0;
          if (rq(1 - x) != 0) begin m_owner = 1 - x; m_sel = 1 - x; m_last = 1 - x; end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    int ev;
    ev = (m_owner >= 0 && rq(m_owner) != 0) ? 1 : 0;
    chk("sel",       int'(bus.sel),       m_sel);
    chk("gnt_0",     int'(bus.gnt_0),     (m_owner == 0) ? 1 : 0);
    chk("gnt_1",     int'(bus.gnt_1),     (m_owner == 1) ? 1 : 0);
    chk("out_valid", int'(bus.out_valid), ev);
    chk("burst_cnt", int'(bus.burst_cnt), m_cnt);
    chk("cnt_bound", int'(bus.burst_cnt < 8'(BM)), 1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic r0, input logic r1, input logic rdy);
    bus.req_0 = r0; bus.req_1 = r1; bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    set_in(0, 0, 0);
    step(); step();
    rst = 1'b0;

    // T1: async reset mid-cycle while owning with both requests high.
    set_in(1, 1, 1);
    step(); step();
    #2 rst = 1'b1;
    #1;
    chk("t1_sel",   int'(bus.sel),       0);
    chk("t1_gnt0",  int'(bus.gnt_0),     0);
    chk("t1_gnt1",  int'(bus.gnt_1),     0);
    chk("t1_valid", int'(bus.out_valid), 0);
    chk("t1_cnt",   int'(bus.burst_cnt), 0);
    step();
    rst = 1'b0;
    set_in(1, 0, 1);
    step();
    chk("t1_gnt0_after", int'(bus.gnt_0), 1);
    chk("t1_sel_after",  int'(bus.sel),   0);

    // T2: forced alternation every BM transfers, no valid gap.
    do_reset();
    set_in(1, 1, 1);
    step();
    for (int i = 0; i < 16; i++) begin
      chk("t2_sel",   int'(bus.sel),       (i / BM) % 2);
      chk("t2_cnt",   int'(bus.burst_cnt), i % BM);
      chk("t2_valid", int'(bus.out_valid), 1);
      step();
    end

    // T3: backpressure at burst_cnt=2 holds everything.
    do_reset();
    set_in(1, 1, 1);
    step(); step(); step();
    chk("t3_cnt_pre", int'(bus.burst_cnt), 2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_valid", int'(bus.out_valid), 1);
      chk("t3_sel",   int'(bus.sel),       0);
      chk("t3_cnt",   int'(bus.burst_cnt), 2);
    end
    bus.out_ready = 1'b1;
    step();
    chk("t3_cnt_3rd", int'(bus.burst_cnt), 3);
    step();
    chk("t3_switch", int'(bus.sel), 1);

    // T4: early release with and without a waiting peer.
    do_reset();
    set_in(1, 1, 1);
    step(); step();
    bus.req_0 = 1'b0;
    step();
    chk("t4_gnt1", int'(bus.gnt_1),     1);
    chk("t4_sel",  int'(bus.sel),       1);
    chk("t4_cnt",  int'(bus.burst_cnt), 0);
    do_reset();
    set_in(1, 0, 1);
    step(); step();
    bus.req_0 = 1'b0;
    step();
    chk("t4_idle_valid", int'(bus.out_valid), 0);
    chk("t4_idle_gnt0",  int'(bus.gnt_0),     0);
    chk("t4_idle_sel",   int'(bus.sel),       0);

    // T5: lone requester wraps its burst without losing the grant.
    do_reset();
    set_in(0, 1, 1);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("t5_gnt1", int'(bus.gnt_1),     1);
      chk("t5_cnt",  int'(bus.burst_cnt), i % BM);
      step();
    end

    // T6: simultaneous first request after source 0 owned last.
    do_reset();
    set_in(1, 0, 1);
    step();
    bus.req_0 = 1'b0;
    step();
    chk("t6_idle", int'(bus.gnt_0 | bus.gnt_1), 0);
    set_in(1, 1, 1);
    step();
    chk("t6_gnt1", int'(bus.gnt_1), 1);
    chk("t6_sel",  int'(bus.sel),   1);

    // Randomized traffic with occasional mid-cycle resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
